lane_walk_sched: RTL and testbench

- Scheduler that sequences a one-hot strobe across a parameterised array of WID target lanes.
- Each enabled lane sees exactly one rising edge per pass, visited in ascending lane order. Lanes excluded by a mask are skipped with zero cycle cost.
- The number of passes is programmable.
- Sits above a generate-loop instance array. It drives each lane's clock/strobe bit, replacing free-running testbench walking-one logic.

---
 rtl/lane_walk_pkg.sv | 33 +++
 rtl/lane_find_next.sv | 41 ++++
 rtl/lane_walk_sched.sv | 137 +++++++++++++
 tb/tb_lane_walk_sched.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lane_walk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lane_walk_pkg
//  Brief    : Shared state encoding and width helper for the lane-walk
//             strobe scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package lane_walk_pkg;

    // Sequencer state encodings, kept as fixed-width constants so that
    // older code comparing raw state bits keeps working.
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HI   = 2'd1;
    localparam logic [1:0] c_ST_LO   = 2'd2;
    localparam logic [1:0] c_ST_FIN  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_HI   = c_ST_HI,
        ST_LO   = c_ST_LO,
        ST_FIN  = c_ST_FIN
    } lw_state_e;

    // Lane index width; a single-lane array still needs one index bit.
    function automatic int calc_iw(input int wid);
        if (wid <= 1) begin
            return 1;
        end
        return $clog2(wid);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_find_next.sv
`default_nettype none
// ============================================================================
//  Module   : lane_find_next
//  Brief    : Combinational priority finder over a lane mask. Reports the
//             lowest set lane strictly above the current index, and the
//             lowest set lane overall, each with a found flag.
//  Revision : 1.0  initial release
// ============================================================================
module lane_find_next #(
    parameter int WID = 5,
    parameter int IW  = 3
) (
    input  logic [WID-1:0] mask,
    input  logic [IW-1:0]  cur,
    output logic [IW-1:0]  nxt_idx,
    output logic           nxt_found,
    output logic [IW-1:0]  low_idx,
    output logic           low_found
);

    // Scan from the top lane down so the lowest qualifying lane is the
    // last one written and therefore wins.
    always_comb begin
        nxt_idx   = '0;
        nxt_found = 1'b0;
        low_idx   = '0;
        low_found = 1'b0;
        for (int i = WID - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx   = IW'(i);
                low_found = 1'b1;
                if (i > int'(cur)) begin
                    nxt_idx   = IW'(i);
                    nxt_found = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lane_walk_sched.sv
`default_nettype none
// ============================================================================
//  Module   : lane_walk_sched
//  Brief    : Walks a one-hot strobe across WID lanes in ascending order,
//             skipping masked-off lanes at no cycle cost, for a programmable
//             number of passes. Each visited lane gets one HI cycle followed
//             by one LO cycle, so each lane sees exactly one rising edge per
//             pass. A stall input freezes the walk without adding edges.
//  Revision : 1.0  initial release
// ============================================================================
module lane_walk_sched
    import lane_walk_pkg::*;
#(
    parameter  int WID = 5,
    parameter  int CW  = 8,
    localparam int IW  = calc_iw(WID)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [WID-1:0] mask,
    input  logic [CW-1:0]  passes,
    input  logic           stall,
    output logic [WID-1:0] strobe,
    output logic [IW-1:0]  lane_idx,
    output logic           busy,
    output logic           done,
    output logic [CW-1:0]  pass_cnt
);

    lw_state_e      r_state;
    logic [WID-1:0] r_mask;
    logic [CW-1:0]  r_passes;
    logic [CW-1:0]  r_pass_cnt;
    logic [IW-1:0]  r_lane;
    logic [WID-1:0] r_strobe;

    logic [WID-1:0] w_find_mask;
    logic [IW-1:0]  w_nxt_idx;
    logic           w_nxt_found;
    logic [IW-1:0]  w_low_idx;
    logic           w_low_found;
    logic [WID-1:0] w_nxt_onehot;
    logic [WID-1:0] w_low_onehot;
    logic [CW-1:0]  w_pass_inc;

    // In IDLE the finder looks at the live mask so the first lane is known
    // on the accepting edge; during a run it only sees the latched copy.
    assign w_find_mask = (r_state == ST_IDLE) ? mask : r_mask;

    lane_find_next #(
        .WID (WID),
        .IW  (IW)
    ) u_find (
        .mask      (w_find_mask),
        .cur       (r_lane),
        .nxt_idx   (w_nxt_idx),
        .nxt_found (w_nxt_found),
        .low_idx   (w_low_idx),
        .low_found (w_low_found)
    );

    assign w_nxt_onehot = WID'(1) << w_nxt_idx;
    assign w_low_onehot = WID'(1) << w_low_idx;
    assign w_pass_inc   = r_pass_cnt + CW'(1);

    // Sequencer: IDLE -> (HI -> LO)* -> FIN -> IDLE, with stall holding
    // every register while in HI or LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_mask     <= '0;
            r_passes   <= '0;
            r_pass_cnt <= '0;
            r_lane     <= '0;
            r_strobe   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mask     <= mask;
                        r_passes   <= passes;
                        r_pass_cnt <= '0;
                        if (!w_low_found || (passes == '0)) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_state  <= ST_HI;
                            r_lane   <= w_low_idx;
                            r_strobe <= w_low_onehot;
                        end
                    end
                end
                ST_HI: begin
                    if (!stall) begin
                        r_state  <= ST_LO;
                        r_strobe <= '0;
                    end
                end
                ST_LO: begin
                    if (!stall) begin
                        if (w_nxt_found) begin
                            r_state  <= ST_HI;
                            r_lane   <= w_nxt_idx;
                            r_strobe <= w_nxt_onehot;
                        end else begin
                            // End of a pass: count it, then either finish
                            // or wrap back to the lowest enabled lane.
                            r_pass_cnt <= w_pass_inc;
                            if (w_pass_inc == r_passes) begin
                                r_state <= ST_FIN;
                            end else begin
                                r_state  <= ST_HI;
                                r_lane   <= w_low_idx;
                                r_strobe <= w_low_onehot;
                            end
                        end
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_strobe <= '0;
                end
            endcase
        end
    end

    assign strobe   = r_strobe;
    assign lane_idx = r_lane;
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_FIN);
    assign pass_cnt = r_pass_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lane_walk_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lane_walk_sched
//  Brief    : Self-checking bench for lane_walk_sched (WID=5, CW=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_lane_walk_sched;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] mask;
    logic [7:0] passes;
    logic       stall;
    logic [4:0] strobe;
    logic [2:0] lane_idx;
    logic       busy;
    logic       done;
    logic [7:0] pass_cnt;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [4:0] mask;
        logic [7:0] passes;
        int         done_c;
        int         exp_pc;
    } vec_t;

    vec_t vecs[7];

    lane_walk_sched #(
        .WID (5),
        .CW  (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mask     (mask),
        .passes   (passes),
        .stall    (stall),
        .strobe   (strobe),
        .lane_idx (lane_idx),
        .busy     (busy),
        .done     (done),
        .pass_cnt (pass_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Runs one start with the given mask/passes. Cycle 0 is the start
    // cycle; expected strobes come from a list of lanes built from the mask.
    // With noise set, start is re-pulsed mid-run and during FIN (plus a
    // stall during FIN) and must have no effect.
    task automatic run_vec(input logic [4:0] m, input logic [7:0] p,
                           input int done_c, input int exp_pc, input bit noise);
        int q[$];
        int k;
        logic [4:0] exp_s;
        for (int pp = 0; pp < int'(p); pp++)
            for (int i = 0; i < 5; i++)
                if (m[i]) q.push_back(i);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        start  = 1'b1;
        mask   = m;
        passes = p;
        for (int c = 1; c <= done_c + 1; c++) begin
            @(negedge clk);
            start  = 1'b0;
            mask   = 5'($urandom);
            passes = 8'($urandom);
            if (noise && (c == 3 || c == done_c)) start = 1'b1;
            stall = noise && (c == done_c);
            if (c < done_c) begin
                k = (c - 1) / 2;
                exp_s = ((c - 1) % 2 == 0) ? (5'd1 << q[k]) : 5'd0;
                chk("run_strobe", 32'(strobe), 32'(exp_s));
                chk("run_busy", 32'(busy), 32'd1);
                chk("run_done", 32'(done), 32'd0);
                if ((c - 1) % 2 == 0) chk("run_lane_idx", 32'(lane_idx), 32'(q[k]));
            end else if (c == done_c) begin
                chk("fin_strobe", 32'(strobe), 32'd0);
                chk("fin_busy", 32'(busy), 32'd1);
                chk("fin_done", 32'(done), 32'd1);
                chk("fin_pass_cnt", 32'(pass_cnt), 32'(exp_pc));
            end else begin
                chk("post_busy", 32'(busy), 32'd0);
                chk("post_done", 32'(done), 32'd0);
                chk("post_strobe", 32'(strobe), 32'd0);
                chk("post_pass_cnt", 32'(pass_cnt), 32'(exp_pc));
            end
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        int exps[14];
        int edges;
        logic prev;

        n_checks = 0;
        n_errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        mask   = '0;
        passes = '0;
        stall  = 1'b0;

        vecs[0] = '{mask: 5'b11111, passes: 8'd1, done_c: 11, exp_pc: 1};
        vecs[1] = '{mask: 5'b10100, passes: 8'd2, done_c: 9,  exp_pc: 2};
        vecs[2] = '{mask: 5'b00000, passes: 8'd3, done_c: 1,  exp_pc: 0};
        vecs[3] = '{mask: 5'b01010, passes: 8'd0, done_c: 1,  exp_pc: 0};
        vecs[4] = '{mask: 5'b00001, passes: 8'd3, done_c: 7,  exp_pc: 3};
        vecs[5] = '{mask: 5'b10000, passes: 8'd1, done_c: 3,  exp_pc: 1};
        vecs[6] = '{mask: 5'b01101, passes: 8'd2, done_c: 13, exp_pc: 2};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_strobe", 32'(strobe), 32'd0);
        chk("rst_lane_idx", 32'(lane_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass_cnt", 32'(pass_cnt), 32'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++)
            run_vec(vecs[v].mask, vecs[v].passes, vecs[v].done_c, vecs[v].exp_pc, 1'b0);

        // Start re-pulsed while busy and during FIN
        run_vec(5'b10100, 8'd2, 9, 2, 1'b1);

        // Stall held for 3 cycles during the HI on lane1
        exps = '{1, 0, 2, 2, 2, 2, 0, 4, 0, 8, 0, 16, 0, 0};
        edges = 0;
        prev  = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        mask   = 5'b11111;
        passes = 8'd1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = 1'b0;
            stall = (c >= 3 && c <= 5);
            if (strobe[1] && !prev) edges++;
            prev = strobe[1];
            if (c <= 14) begin
                chk("stall_strobe", 32'(strobe), 32'(exps[c-1]));
                chk("stall_done", 32'(done), (c == 14) ? 32'd1 : 32'd0);
            end else begin
                chk("stall_post_busy", 32'(busy), 32'd0);
                chk("stall_pass_cnt", 32'(pass_cnt), 32'd1);
            end
        end
        stall = 1'b0;
        chk("stall_lane1_edges", 32'(edges), 32'd1);

        // Asynchronous reset during a LO cycle of pass 1
        @(negedge clk);
        start  = 1'b1;
        mask   = 5'b11111;
        passes = 8'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_lo_strobe", 32'(strobe), 32'd0);
        chk("pre_rst_lane_idx", 32'(lane_idx), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_strobe", 32'(strobe), 32'd0);
        chk("async_rst_lane_idx", 32'(lane_idx), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_pass_cnt", 32'(pass_cnt), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("in_rst_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        run_vec(5'b11111, 8'd1, 11, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
